// File: rtl/hqm_rcfwl_gclk_rlink_sync_rpt.sv
// Global-clock rlink repeater hop: passes the spine clock through, fans the PLL sync
// pulse out through a programmable retiming delay line and tracks sync periodicity.
module hqm_rcfwl_gclk_rlink_sync_rpt #(
    parameter int NUM_CH   = 4,
    parameter int MAX_DLY  = 8,
    parameter int DLY_W    = 3,
    parameter int PERIOD_W = 8,
    parameter int LOCK_CNT = 3
) (
    input  logic                clkspine_in,
    input  logic                rst,
    input  logic                pll_sync_in,
    input  logic [DLY_W-1:0]    cfg_dly,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                err_clr,
    output logic                ckpredop,
    output logic [NUM_CH-1:0]   pll_sync_out,
    output logic                sync_locked,
    output logic                sync_err,
    output logic [3:0]          miss_cnt
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t              state_reg;
    logic [GOOD_W-1:0]   good_reg;
    logic                s0_reg;
    logic [MAX_DLY-1:1]  dly_reg;
    logic [MAX_DLY-1:0]  d_tap;
    logic                tap;
    logic [NUM_CH-1:0]   out_next;
    logic [PERIOD_W-1:0] cnt_reg;
    logic [DLY_W-1:0]    cfg_dly_reg;
    logic [PERIOD_W-1:0] cfg_period_reg;
    logic                chk_en;
    logic                cfg_chg;
    logic                err_evt;

    assign ckpredop = clkspine_in;

    // d[0] is the registered input itself; deeper taps come from the shift register.
    assign d_tap = {dly_reg, s0_reg};
    assign tap   = d_tap[cfg_dly];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign out_next[gi] = ch_en[gi] & tap;
        end
    endgenerate

    always_ff @(posedge clkspine_in) begin
        if (rst) begin
            s0_reg       <= 1'b0;
            dly_reg      <= '0;
            pll_sync_out <= '0;
        end else begin
            s0_reg       <= pll_sync_in;
            dly_reg      <= {dly_reg[MAX_DLY-2:1], s0_reg};
            pll_sync_out <= out_next;
        end
    end

    always_ff @(posedge clkspine_in) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (s0_reg) begin
            cnt_reg <= PERIOD_W'(1);
        end else if (cnt_reg != {PERIOD_W{1'b1}}) begin
            cnt_reg <= cnt_reg + PERIOD_W'(1);
        end
    end

    assign chk_en  = (cfg_period >= PERIOD_W'(2));
    assign cfg_chg = (cfg_dly != cfg_dly_reg) || (cfg_period != cfg_period_reg);

    // Only a LOCKED checker can raise an error; a config change pre-empts it.
    assign err_evt = chk_en && !cfg_chg && (state_reg == LOCKED) &&
                     ((s0_reg && (cnt_reg < cfg_period)) ||
                      (!s0_reg && (cnt_reg == cfg_period)));

    always_ff @(posedge clkspine_in) begin
        if (rst) begin
            state_reg      <= UNLOCKED;
            good_reg       <= '0;
            cfg_dly_reg    <= '0;
            cfg_period_reg <= '0;
            sync_err       <= 1'b0;
            miss_cnt       <= 4'd0;
        end else begin
            cfg_dly_reg    <= cfg_dly;
            cfg_period_reg <= cfg_period;

            if (!chk_en) begin
                state_reg <= UNLOCKED;
                good_reg  <= '0;
            end else if (cfg_chg && (state_reg == LOCKED || state_reg == ACQUIRE)) begin
                state_reg <= ACQUIRE;
                good_reg  <= '0;
            end else begin
                case (state_reg)
                    UNLOCKED: begin
                        if (s0_reg) begin
                            state_reg <= ACQUIRE;
                            good_reg  <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (s0_reg) begin
                            if (cnt_reg == cfg_period) begin
                                if (good_reg == GOOD_W'(LOCK_CNT - 1)) begin
                                    state_reg <= LOCKED;
                                    good_reg  <= GOOD_W'(LOCK_CNT);
                                end else begin
                                    good_reg <= good_reg + GOOD_W'(1);
                                end
                            end else begin
                                good_reg <= '0;
                            end
                        end else if (cnt_reg == cfg_period) begin
                            good_reg <= '0;
                        end
                    end
                    LOCKED: begin
                        if (err_evt) begin
                            state_reg <= ERROR;
                        end
                    end
                    ERROR: begin
                        state_reg <= ACQUIRE;
                        good_reg  <= '0;
                    end
                    default: begin
                        state_reg <= UNLOCKED;
                        good_reg  <= '0;
                    end
                endcase
            end

            // A simultaneous clear and error restarts the count at one.
            if (err_evt) begin
                sync_err <= 1'b1;
                if (err_clr) begin
                    miss_cnt <= 4'd1;
                end else if (miss_cnt != 4'd15) begin
                    miss_cnt <= miss_cnt + 4'd1;
                end
            end else if (err_clr) begin
                sync_err <= 1'b0;
                miss_cnt <= 4'd0;
            end
        end
    end

    assign sync_locked = (state_reg == LOCKED);

endmodule
